// File: rtl/control_fnn.sv
// Time-multiplexed 4-layer fully-connected classifier: loads a weight/bias stream once,
// then per inference buffers the pixels, runs every neuron on one MAC and reports the argmax.
module control_fnn #(
  parameter int WEIGHT_WIDTH  = 16,
  parameter int PART_NO_WIDTH = 7,
  parameter int INDATA_WIDTH  = 16,
  parameter int NO_OF_INPUTS  = 784,
  parameter int NN1           = 40,
  parameter int NN2           = 10,
  parameter int NN3           = 10,
  parameter int NN4           = 10
) (
  input  logic                                  clk,
  input  logic                                  restart,
  input  logic                                  start_FNN,
  input  logic [WEIGHT_WIDTH+PART_NO_WIDTH-1:0] weight_bus,
  input  logic                                  load_weights,
  input  logic                                  weight_valid,
  input  logic                                  ready_in,
  input  logic [INDATA_WIDTH-1:0]               input_image,
  output logic [3:0]                            max,
  output logic                                  finish_FNN,
  output logic                                  FNN_ready,
  output logic                                  FNN_ready_to_accept
);

  localparam int DEPTH = NO_OF_INPUTS*NN1 + NN1 + NN1*NN2 + NN2 + NN2*NN3 + NN3 + NN3*NN4 + NN4;
  localparam int AW    = $clog2(DEPTH);
  localparam int BIAS1 = NO_OF_INPUTS*NN1;
  localparam int BIAS2 = BIAS1 + NN1 + NN1*NN2;
  localparam int BIAS3 = BIAS2 + NN2 + NN2*NN3;
  localparam int BIAS4 = BIAS3 + NN3 + NN3*NN4;
  localparam int ACT_DEPTH = NO_OF_INPUTS + NN1 + NN2 + NN3;
  localparam int AAW   = $clog2(ACT_DEPTH);
  localparam int M1    = (NO_OF_INPUTS > NN1) ? NO_OF_INPUTS : NN1;
  localparam int M2    = (M1 > NN2) ? M1 : NN2;
  localparam int M3    = (M2 > NN3) ? M2 : NN3;
  localparam int MAXN  = (M3 > NN4) ? M3 : NN4;
  localparam int CW    = $clog2(MAXN + 1);
  localparam int WW    = WEIGHT_WIDTH;
  localparam int PW    = 2 * WEIGHT_WIDTH;
  localparam int ACC_W = 40;
  localparam int FRAC  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_MAC    = 3'd2,
    S_BIAS   = 3'd3,
    S_ACT    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t r_state, w_state_next;

  // Load bookkeeping survives restart; the flag must power up clear.
  logic          r_load_d = 1'b0;
  logic          r_loaded = 1'b0;
  logic [AW-1:0] r_ld_addr;
  logic          w_load_rise, w_loaded_eff, w_wr_en, w_wr_last;
  logic [AW-1:0] w_ld_addr_eff;
  logic          w_unused_part;

  logic [WW-1:0] r_wmem [0:DEPTH-1];
  logic [WW-1:0] r_amem [0:ACT_DEPTH-1];

  logic [CW-1:0]           r_inp, r_neu, w_n_in, w_n_out;
  logic [1:0]              r_layer;
  logic [AW-1:0]           r_waddr, w_bias_base, w_rd_addr;
  logic [AAW-1:0]          w_src_base, w_dst_base, w_src_addr, w_dst_addr;
  logic signed [WW-1:0]    r_w, r_a;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] r_acc, w_acc_mac, w_sum, r_best;
  logic [WW-1:0]           w_relu;
  logic                    r_mac_v, w_last_inp, w_last_neu, w_better;
  logic [3:0]              r_best_idx, r_max;
  logic                    r_finish, r_accept;

  assign w_unused_part = ^weight_bus[WEIGHT_WIDTH+PART_NO_WIDTH-1:WEIGHT_WIDTH];
  assign w_load_rise   = load_weights & ~r_load_d;
  assign w_ld_addr_eff = w_load_rise ? {AW{1'b0}} : r_ld_addr;
  assign w_loaded_eff  = w_load_rise ? 1'b0 : r_loaded;
  assign w_wr_en       = load_weights & weight_valid & ~w_loaded_eff;
  assign w_wr_last     = w_wr_en & (w_ld_addr_eff == AW'(DEPTH - 1));

  // Weight-load address and loaded flag
  always_ff @(posedge clk) begin
    r_load_d  <= load_weights;
    r_loaded  <= w_loaded_eff | w_wr_last;
    r_ld_addr <= (w_wr_en && !w_wr_last) ? w_ld_addr_eff + AW'(1) : w_ld_addr_eff;
  end

  // Weight memory write port
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_wmem[w_ld_addr_eff] <= weight_bus[WW-1:0];
    end
  end

  // Per-layer geometry; activations of all layers share one buffer at fixed offsets
  always_comb begin
    w_n_in      = CW'(NO_OF_INPUTS);
    w_n_out     = CW'(NN1);
    w_bias_base = AW'(BIAS1);
    w_src_base  = AAW'(0);
    w_dst_base  = AAW'(NO_OF_INPUTS);
    case (r_layer)
      2'd1: begin
        w_n_in = CW'(NN1); w_n_out = CW'(NN2); w_bias_base = AW'(BIAS2);
        w_src_base = AAW'(NO_OF_INPUTS); w_dst_base = AAW'(NO_OF_INPUTS + NN1);
      end
      2'd2: begin
        w_n_in = CW'(NN2); w_n_out = CW'(NN3); w_bias_base = AW'(BIAS3);
        w_src_base = AAW'(NO_OF_INPUTS + NN1); w_dst_base = AAW'(NO_OF_INPUTS + NN1 + NN2);
      end
      2'd3: begin
        w_n_in = CW'(NN3); w_n_out = CW'(NN4); w_bias_base = AW'(BIAS4);
        w_src_base = AAW'(NO_OF_INPUTS + NN1 + NN2); w_dst_base = AAW'(0);
      end
      default: ;
    endcase
  end

  assign w_last_inp = (r_inp == w_n_in - CW'(1));
  assign w_last_neu = (r_neu == w_n_out - CW'(1));
  assign w_src_addr = w_src_base + AAW'(r_inp);
  assign w_dst_addr = w_dst_base + AAW'(r_neu);
  assign w_rd_addr  = (r_state == S_BIAS) ? w_bias_base + AW'(r_neu) : r_waddr;
  assign w_prod     = r_w * r_a;
  assign w_acc_mac  = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_sum      = r_acc + {{(ACC_W-WW-FRAC){r_w[WW-1]}}, r_w, {FRAC{1'b0}}};
  assign w_better   = (r_neu == CW'(0)) || (w_sum > r_best);

  // ReLU, rescale Q16.16 -> Q8.8 and saturate to the positive range
  always_comb begin
    if (w_sum[ACC_W-1]) begin
      w_relu = {WW{1'b0}};
    end else if (|w_sum[ACC_W-2:FRAC+WW-1]) begin
      w_relu = {1'b0, {(WW-1){1'b1}}};
    end else begin
      w_relu = w_sum[FRAC+WW-1:FRAC];
    end
  end

  // Operand fetch: one weight/bias word and one activation per cycle
  always_ff @(posedge clk) begin
    r_w <= r_wmem[w_rd_addr];
    r_a <= r_amem[w_src_addr];
  end

  // Activation buffer: pixels while accepting, hidden-layer outputs while computing
  always_ff @(posedge clk) begin
    if (r_state == S_ACCEPT && ready_in) begin
      r_amem[AAW'(r_inp)] <= WW'(input_image);
    end else if (r_state == S_ACT && r_layer != 2'd3) begin
      r_amem[w_dst_addr] <= w_relu;
    end
  end

  // State register
  always_ff @(posedge clk or posedge restart) begin
    if (restart) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   w_state_next = (start_FNN && r_loaded && !load_weights) ? S_ACCEPT : S_IDLE;
      S_ACCEPT: w_state_next = (ready_in && r_inp == CW'(NO_OF_INPUTS - 1)) ? S_MAC : S_ACCEPT;
      S_MAC:    w_state_next = w_last_inp ? S_BIAS : S_MAC;
      S_BIAS:   w_state_next = S_ACT;
      S_ACT:    w_state_next = (w_last_neu && r_layer == 2'd3) ? S_DONE : S_MAC;
      S_DONE:   w_state_next = S_DONE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Counters, accumulator, argmax tracking and registered outputs
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_inp <= '0; r_neu <= '0; r_layer <= 2'd0; r_waddr <= '0;
      r_acc <= '0; r_mac_v <= 1'b0; r_best <= '0; r_best_idx <= 4'd0;
      r_max <= 4'd0; r_finish <= 1'b0; r_accept <= 1'b0;
    end else begin
      r_accept <= (w_state_next == S_ACCEPT);
      r_finish <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          r_inp <= '0; r_neu <= '0; r_layer <= 2'd0; r_waddr <= '0;
          r_acc <= '0; r_mac_v <= 1'b0;
        end
        S_ACCEPT: begin
          if (ready_in) r_inp <= (r_inp == CW'(NO_OF_INPUTS - 1)) ? CW'(0) : r_inp + CW'(1);
        end
        S_MAC: begin
          r_waddr <= r_waddr + AW'(1);
          r_mac_v <= 1'b1;
          r_inp   <= w_last_inp ? CW'(0) : r_inp + CW'(1);
          if (r_mac_v) r_acc <= w_acc_mac;
        end
        S_BIAS: begin
          r_acc   <= w_acc_mac;
          r_mac_v <= 1'b0;
        end
        S_ACT: begin
          r_acc <= '0;
          if (r_layer == 2'd3 && w_better) begin
            r_best     <= w_sum;
            r_best_idx <= 4'(r_neu);
          end
          if (w_last_neu) begin
            r_neu   <= '0;
            r_layer <= r_layer + 2'd1;
            // weight pointer sits on this layer's biases; skip them to the next layer
            r_waddr <= r_waddr + AW'(w_n_out);
            if (r_layer == 2'd3) r_max <= w_better ? 4'(r_neu) : r_best_idx;
          end else begin
            r_neu <= r_neu + CW'(1);
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  assign max                 = r_max;
  assign finish_FNN          = r_finish;
  assign FNN_ready           = r_loaded;
  assign FNN_ready_to_accept = r_accept;

endmodule

// File: tb/tb_control_fnn.sv
// Randomized bench for control_fnn on a reduced network, checked against a
// layer-by-layer arithmetic model of the classifier.
module tb_control_fnn;
  localparam int NI  = 8;
  localparam int NN1 = 4;
  localparam int NN2 = 3;
  localparam int NN3 = 3;
  localparam int NN4 = 10;
  localparam int DEPTH = NI*NN1 + NN1 + NN1*NN2 + NN2 + NN2*NN3 + NN3 + NN3*NN4 + NN4;

  logic        clk = 1'b0;
  logic        restart, start_FNN, load_weights, weight_valid, ready_in;
  logic [22:0] weight_bus;
  logic [15:0] input_image;
  logic [3:0]  max;
  logic        finish_FNN, FNN_ready, FNN_ready_to_accept;

  int total = 0;
  int bad   = 0;
  int wts [DEPTH];
  int pix [NI];

  control_fnn #(
    .WEIGHT_WIDTH(16), .PART_NO_WIDTH(7), .INDATA_WIDTH(16),
    .NO_OF_INPUTS(NI), .NN1(NN1), .NN2(NN2), .NN3(NN3), .NN4(NN4)
  ) dut (
    .clk(clk), .restart(restart), .start_FNN(start_FNN), .weight_bus(weight_bus),
    .load_weights(load_weights), .weight_valid(weight_valid), .ready_in(ready_in),
    .input_image(input_image), .max(max), .finish_FNN(finish_FNN),
    .FNN_ready(FNN_ready), .FNN_ready_to_accept(FNN_ready_to_accept)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference classifier: plain signed arithmetic over the stream layout
  function automatic int ref_argmax();
    longint cur [64];
    longint nxt [64];
    longint s, best;
    int sizes [5];
    int base, nin, nout, idx;
    sizes = '{NI, NN1, NN2, NN3, NN4};
    for (int i = 0; i < NI; i++) cur[i] = pix[i];
    base = 0; idx = 0; best = 0;
    for (int l = 0; l < 4; l++) begin
      nin = sizes[l]; nout = sizes[l+1];
      for (int j = 0; j < nout; j++) begin
        s = 0;
        for (int i = 0; i < nin; i++) s += longint'(wts[base + j*nin + i]) * cur[i];
        s += longint'(wts[base + nin*nout + j]) * 256;
        if (l < 3) begin
          if (s < 0) nxt[j] = 0;
          else if (s / 256 > 32767) nxt[j] = 32767;
          else nxt[j] = s / 256;
        end else if (j == 0 || s > best) begin
          best = s; idx = j;
        end
      end
      base += nin*nout + nout;
      for (int j = 0; j < nout; j++) cur[j] = nxt[j];
    end
    return idx;
  endfunction

  task automatic load_stream();
    int n;
    @(negedge clk);
    load_weights = 1'b1; weight_valid = 1'b0; start_FNN = 1'b1;
    @(negedge clk);
    chk("ready_cleared_on_load", FNN_ready, 0);
    for (int k = 0; k < DEPTH; k++) begin
      n = $urandom_range(0, 2);
      repeat (n) begin weight_valid = 1'b0; @(negedge clk); end
      weight_valid = 1'b1;
      weight_bus = {7'($urandom_range(0, 127)), 16'(wts[k])};
      if (k == DEPTH - 1) chk("ready_not_early", FNN_ready, 0);
      @(negedge clk);
    end
    chk("ready_after_last", FNN_ready, 1);
    for (int k = 0; k < 3; k++) begin
      weight_bus = 23'($urandom);
      @(negedge clk);
    end
    weight_valid = 1'b0;
    chk("no_start_while_loading", FNN_ready_to_accept, 0);
    start_FNN = 1'b0;
    @(negedge clk);
    load_weights = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_restart(input string tag);
    start_FNN = 1'b0; ready_in = 1'b0;
    #2 restart = 1'b1;
    #1;
    chk({tag, "_max"}, max, 0);
    chk({tag, "_finish"}, finish_FNN, 0);
    chk({tag, "_accept"}, FNN_ready_to_accept, 0);
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  // Start an inference and hand over up to npix pixels through the handshake
  task automatic feed(input int npix, output int k);
    int cyc;
    k = 0; cyc = 0;
    start_FNN = 1'b1;
    while (k < npix && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (FNN_ready_to_accept && $urandom_range(0, 3) != 0) begin
        ready_in = 1'b1; input_image = 16'(pix[k]); k++;
      end else begin
        ready_in = 1'b0;
      end
    end
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  task automatic run_inf(input string tag, input int expv);
    int k, cyc;
    feed(NI, k);
    chk({tag, "_pixels"}, k, NI);
    cyc = 0;
    while (!finish_FNN && cyc < 3000) begin @(negedge clk); cyc++; end
    chk({tag, "_finish"}, finish_FNN, 1);
    chk({tag, "_max"}, max, expv);
    repeat (4) @(negedge clk);
    chk({tag, "_held_finish"}, finish_FNN, 1);
    chk({tag, "_held_max"}, max, expv);
    start_FNN = 1'b0;
  endtask

  task automatic rand_image();
    for (int i = 0; i < NI; i++) pix[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  initial begin
    int k, cyc;
    restart = 1'b1; start_FNN = 1'b0; load_weights = 1'b0; weight_valid = 1'b0;
    ready_in = 1'b0; weight_bus = '0; input_image = '0;
    repeat (3) @(negedge clk);
    chk("rst_max", max, 0);
    chk("rst_finish", finish_FNN, 0);
    chk("rst_accept", FNN_ready_to_accept, 0);
    chk("powerup_ready", FNN_ready, 0);
    restart = 1'b0;

    start_FNN = 1'b1;
    repeat (6) @(negedge clk);
    chk("start_unloaded_accept", FNN_ready_to_accept, 0);
    chk("start_unloaded_finish", finish_FNN, 0);
    start_FNN = 1'b0;

    for (int i = 0; i < DEPTH; i++) wts[i] = 0;
    wts[DEPTH - NN4 + 7] = 16'h0100;
    rand_image();
    load_stream();
    run_inf("bias7", 7);
    do_restart("rst_done");
    chk("ready_kept_after_restart", FNN_ready, 1);

    for (int i = 0; i < DEPTH; i++) wts[i] = 0;
    load_stream();
    rand_image();
    run_inf("zero_tie", 0);
    do_restart("rst_zero");
    run_inf("zero_tie_again", 0);
    do_restart("rst_zero2");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) wts[i] = int'($urandom_range(0, 2047)) - 1024;
      load_stream();
      for (int m = 0; m < 3; m++) begin
        rand_image();
        run_inf($sformatf("rand%0d_%0d", r, m), ref_argmax());
        do_restart("rst_rand");
      end
    end

    rand_image();
    feed(3, k);
    chk("abort_acc_active", FNN_ready_to_accept, 1);
    do_restart("abort_accept");
    run_inf("after_abort_accept", ref_argmax());
    do_restart("rst_a1");

    rand_image();
    feed(NI, k);
    cyc = 0;
    while (FNN_ready_to_accept && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (10) @(negedge clk);
    chk("abort_cmp_busy", finish_FNN, 0);
    do_restart("abort_compute");
    run_inf("after_abort_compute", ref_argmax());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
